// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//
// Contents:
//   state_e     - controller FSM states
//   OP_*        - recognised 6-bit primary opcodes (IR[31:26])
//   opclass_e   - decoded instruction class used for dispatch
//   aluop_e, alusrcb_e, pcsrc_e, regdst_e, wrsrc_e - datapath select encodings
//   ctrl_t      - bundle of every control output driven by the FSM
//   is_wait_state() - states that hold the shared memory port and may stall
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_WB_R,
        ST_EXEC_I,
        ST_WB_I,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_WB_LW,
        ST_MEM_WR,
        ST_BRANCH,
        ST_JUMP,
        ST_JAL,
        ST_ERROR
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JAL  = 6'b011000;
    localparam logic [5:0] OP_BEQ  = 6'b100000;
    localparam logic [5:0] OP_BNE  = 6'b101000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SLTI = 6'b010001;
    localparam logic [5:0] OP_LW   = 6'b011100;
    localparam logic [5:0] OP_SW   = 6'b011101;

    typedef enum logic [3:0] {
        OPC_R,
        OPC_J,
        OPC_JAL,
        OPC_BEQ,
        OPC_BNE,
        OPC_ADDI,
        OPC_SLTI,
        OPC_LW,
        OPC_SW,
        OPC_ILLEGAL
    } opclass_e;

    typedef enum logic [1:0] {
        ALUOP_FUNCT = 2'b00,
        ALUOP_ADD   = 2'b01,
        ALUOP_SUB   = 2'b10,
        ALUOP_SLT   = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

    typedef enum logic [1:0] {
        REGDST_RT  = 2'b00,
        REGDST_RD  = 2'b01,
        REGDST_R31 = 2'b10
    } regdst_e;

    typedef enum logic [1:0] {
        WRSRC_ALUOUT = 2'b00,
        WRSRC_MDR    = 2'b01,
        WRSRC_PC     = 2'b10
    } wrsrc_e;

    typedef struct packed {
        logic     pcwrite;
        logic     irwrite;
        logic     memread;
        logic     memwrite;
        logic     regwrite;
        logic     iord;
        logic     alusrca;
        alusrcb_e alusrcb;
        aluop_e   aluop;
        pcsrc_e   pcsrc;
        regdst_e  regdst;
        wrsrc_e   wrsrc;
        logic     instr_done;
    } ctrl_t;

    // States that own the memory port and wait for mem_ready.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Bounded-wait counter for memory accesses.
//
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   clear     - zero the count (used whenever no access is pending)
//   count_en  - one more cycle spent waiting for mem_ready
//   expired   - this is the TIMEOUT-th wait cycle and it is still not ready
//
// The count saturates at TIMEOUT so it can never wrap back into range.
module ctrl_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of earlier unanswered wait cycles, so
    // LAST means the current cycle is the final one allowed.
    assign expired = count_en && (count_q == LAST);

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control unit (Moore FSM, one instruction at a time).
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   opcode          - IR[31:26], valid from DECODE onward
//   zero            - ALU zero flag, used by beq/bne
//   mem_ready       - shared memory port completes this cycle
//   pcwrite .. wrsrc - datapath enables and selects
//   instr_done      - pulses on the last cycle of each instruction
//   illegal         - sticky: an unknown opcode was decoded
//   err             - sticky: a memory access timed out, FSM parked in ERROR
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pcwrite,
    output logic           irwrite,
    output logic           memread,
    output logic           memwrite,
    output logic           regwrite,
    output logic           iord,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     aluop,
    output logic [1:0]     pcsrc,
    output logic [1:0]     regdst,
    output logic [1:0]     wrsrc,
    output logic           instr_done,
    output logic           illegal,
    output logic           err
);

    state_e   state_q;
    state_e   state_d;
    opclass_e op_class;
    ctrl_t    ctrl;
    logic     illegal_q;
    logic     illegal_d;
    logic     err_q;
    logic     err_d;
    logic     in_wait;
    logic     timer_expired;

    // IR only changes in FETCH, so opcode can be decoded straight from the
    // input in every later state without a private copy.
    always_comb begin
        op_class = OPC_ILLEGAL;
        case (opcode)
            OPW'(OP_R):    op_class = OPC_R;
            OPW'(OP_J):    op_class = OPC_J;
            OPW'(OP_JAL):  op_class = OPC_JAL;
            OPW'(OP_BEQ):  op_class = OPC_BEQ;
            OPW'(OP_BNE):  op_class = OPC_BNE;
            OPW'(OP_ADDI): op_class = OPC_ADDI;
            OPW'(OP_SLTI): op_class = OPC_SLTI;
            OPW'(OP_LW):   op_class = OPC_LW;
            OPW'(OP_SW):   op_class = OPC_SW;
            default:       op_class = OPC_ILLEGAL;
        endcase
    end

    // The timer runs only while a memory access is outstanding; any other
    // state or a completed access leaves it at zero for the next access.
    assign in_wait = is_wait_state(state_q);

    ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!in_wait || mem_ready),
        .count_en (in_wait && !mem_ready),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic. A ready on the last allowed wait cycle wins over
    // the timeout, so ready is tested before expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                case (op_class)
                    OPC_R:             state_d = ST_EXEC_R;
                    OPC_ADDI, OPC_SLTI: state_d = ST_EXEC_I;
                    OPC_LW, OPC_SW:    state_d = ST_MEM_ADDR;
                    OPC_BEQ, OPC_BNE:  state_d = ST_BRANCH;
                    OPC_J:             state_d = ST_JUMP;
                    OPC_JAL:           state_d = ST_JAL;
                    default:           state_d = ST_FETCH;
                endcase
            end
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_WB_R:     state_d = ST_FETCH;
            ST_EXEC_I:   state_d = ST_WB_I;
            ST_WB_I:     state_d = ST_FETCH;
            ST_MEM_ADDR: state_d = (op_class == OPC_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_d = ST_WB_LW;
                end else if (timer_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WB_LW:    state_d = ST_FETCH;
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (timer_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_JAL:      state_d = ST_FETCH;
            ST_ERROR:    state_d = ST_ERROR;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Sticky status: only reset clears them.
    always_comb begin
        illegal_d = illegal_q || ((state_q == ST_DECODE) && (op_class == OPC_ILLEGAL));
        err_d     = err_q || (state_d == ST_ERROR);
    end

    // Output logic. Everything defaults to zero, so ERROR drives no enables.
    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            ST_DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                ctrl.alusrcb    = SRCB_IMM_SH2;
                ctrl.aluop      = ALUOP_ADD;
                ctrl.instr_done = (op_class == OPC_ILLEGAL);
            end
            ST_EXEC_R: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ST_WB_R: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = REGDST_RD;
                ctrl.wrsrc      = WRSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            ST_EXEC_I: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = (op_class == OPC_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            ST_WB_I: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = REGDST_RT;
                ctrl.wrsrc      = WRSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_WB_LW: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = REGDST_RT;
                ctrl.wrsrc      = WRSRC_MDR;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.memwrite   = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_REG;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.pcwrite    = (op_class == OPC_BNE) ? !zero : zero;
                ctrl.instr_done = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pcwrite    = 1'b1;
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_JAL: begin
                // PC already holds PC+4 from FETCH, which is the link value.
                ctrl.pcwrite    = 1'b1;
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = REGDST_R31;
                ctrl.wrsrc      = WRSRC_PC;
                ctrl.instr_done = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign pcwrite    = ctrl.pcwrite;
    assign irwrite    = ctrl.irwrite;
    assign memread    = ctrl.memread;
    assign memwrite   = ctrl.memwrite;
    assign regwrite   = ctrl.regwrite;
    assign iord       = ctrl.iord;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign aluop      = ctrl.aluop;
    assign pcsrc      = ctrl.pcsrc;
    assign regdst     = ctrl.regdst;
    assign wrsrc      = ctrl.wrsrc;
    assign instr_done = ctrl.instr_done;
    assign illegal    = illegal_q;
    assign err        = err_q;

endmodule
